// File: rtl/lsu_data_mem.sv
// Single-port RV32I load/store data memory with byte-lane stores, sign-extending loads,
// fixed response latency and a post-reset scrub that zeroes every word before use.
module lsu_data_mem #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ReqValid,
  output logic                  o_ReqReady,
  input  logic                  i_WrEn,
  input  logic [2:0]            i_Funct3,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic [31:0]           i_DataIn,
  output logic                  o_RespValid,
  output logic [31:0]           o_DataOut,
  output logic [1:0]            o_Err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] scrub_ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      held_data;
  logic [1:0]       held_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic              accept;
  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              illegal;
  logic              misaligned;
  logic [1:0]        req_err;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic [31:0]       resp_data;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  // Request decode, error classification and load extraction for the word at the request address.
  always_comb begin
    accept   = (state == S_IDLE) && i_ReqValid && !reset;
    word_idx = i_Addr[ADDR_WIDTH-1:2];
    lane     = i_Addr[1:0];
    mem_idx  = IDX_W'(word_idx);
    in_range = 32'(word_idx) < DEPTH_WORDS;

    if (i_WrEn) begin
      illegal = i_Funct3[2] || (i_Funct3[1:0] == 2'b11);
    end else begin
      illegal = (i_Funct3 == 3'b011) || (i_Funct3[2:1] == 2'b11);
    end

    case (i_Funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane;
      default: misaligned = 1'b0;
    endcase

    if (illegal) begin
      req_err = ERR_FUNCT3;
    end else if (!in_range) begin
      req_err = ERR_RANGE;
    end else if (misaligned) begin
      req_err = ERR_MISALIGN;
    end else begin
      req_err = ERR_OK;
    end

    rd_word = in_range ? mem[mem_idx] : 32'h0;
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (i_Funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase

    resp_data = (i_WrEn || (req_err != ERR_OK)) ? 32'h0 : load_data;
  end

  // Single write port shared by the scrub engine and accepted, error-free stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = scrub_ptr;
    mem_wdata = 32'h0;
    mem_wstrb = 4'b1111;
    if ((state == S_CLEAR) && !reset) begin
      mem_we = 1'b1;
    end else if (accept && i_WrEn && (req_err == ERR_OK)) begin
      mem_we   = 1'b1;
      mem_widx = mem_idx;
      case (i_Funct3[1:0])
        2'b00: begin
          mem_wdata = {4{i_DataIn[7:0]}};
          mem_wstrb = 4'b0001 << lane;
        end
        2'b01: begin
          mem_wdata = {2{i_DataIn[15:0]}};
          mem_wstrb = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = i_DataIn;
          mem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Byte-strobed storage array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) begin
          mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM: scrub, accept one request, wait out the latency, pulse the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CLEAR;
      scrub_ptr   <= '0;
      wait_cnt    <= '0;
      held_data   <= 32'h0;
      held_err    <= ERR_OK;
      o_ReqReady  <= 1'b0;
      o_RespValid <= 1'b0;
      o_DataOut   <= 32'h0;
      o_Err       <= ERR_OK;
    end else begin
      o_RespValid <= 1'b0;
      o_DataOut   <= 32'h0;
      o_Err       <= ERR_OK;
      case (state)
        S_CLEAR: begin
          scrub_ptr <= scrub_ptr + IDX_W'(1);
          if (32'(scrub_ptr) == DEPTH_WORDS - 1) begin
            state      <= S_IDLE;
            scrub_ptr  <= '0;
            o_ReqReady <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            o_ReqReady <= 1'b0;
            if (READ_LATENCY <= 1) begin
              state       <= S_RESP;
              o_RespValid <= 1'b1;
              o_DataOut   <= resp_data;
              o_Err       <= req_err;
            end else begin
              state     <= S_WAIT;
              wait_cnt  <= WAIT_INIT;
              held_data <= resp_data;
              held_err  <= req_err;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= S_RESP;
            o_RespValid <= 1'b1;
            o_DataOut   <= held_data;
            o_Err       <= held_err;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          o_ReqReady <= 1'b1;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: directed vector table, randomized traffic against a byte-level
// reference model, reset scrub timing and reset during an outstanding request.
module tb_lsu_data_mem;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 3;

  logic        clk;
  logic        reset;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_WrEn;
  logic [2:0]  i_Funct3;
  logic [11:0] i_Addr;
  logic [31:0] i_DataIn;
  logic        o_RespValid;
  logic [31:0] o_DataOut;
  logic [1:0]  o_Err;

  lsu_data_mem #(
    .ADDR_WIDTH  (AW),
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_ReqValid (i_ReqValid),
    .o_ReqReady (o_ReqReady),
    .i_WrEn     (i_WrEn),
    .i_Funct3   (i_Funct3),
    .i_Addr     (i_Addr),
    .i_DataIn   (i_DataIn),
    .o_RespValid(o_RespValid),
    .o_DataOut  (o_DataOut),
    .o_Err      (o_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: access size from funct3, then byte-by-byte update or extraction.
  function automatic void model_access(input logic wr, input logic [2:0] f3,
                                       input logic [11:0] addr, input logic [31:0] din,
                                       output logic [31:0] data, output logic [1:0] err);
    int size;
    bit sgn;
    int idx;
    int lane;
    logic [31:0] word;
    logic [31:0] mask;
    size = 0;
    sgn  = 0;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    idx  = int'(addr) / 4;
    lane = int'(addr) % 4;
    data = 32'h0;
    if (size == 0) err = 2'd3;
    else if (idx >= int'(DEPTH)) err = 2'd2;
    else if ((lane % size) != 0) err = 2'd1;
    else err = 2'd0;
    if (err != 2'd0) return;
    word = model_mem[idx];
    if (wr) begin
      for (int b = 0; b < size; b++) word[8*(lane+b) +: 8] = din[8*b +: 8];
      model_mem[idx] = word;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*size)) - 64'd1);
      data = (word >> (8*lane)) & mask;
      if (sgn && (size < 4) && data[8*size-1]) data = data | ~mask;
    end
  endfunction

  // Issue one request from a negedge; checks ready/valid timing; returns DUT and model results.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] din,
                        output logic [31:0] rdata, output logic [1:0] rerr,
                        output logic [31:0] mdata, output logic [1:0] merr);
    int waited = 0;
    bit lat_ok = 1;
    rdata = 32'h0;
    rerr  = 2'd0;
    mdata = 32'h0;
    merr  = 2'd0;
    while (!o_ReqReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_wait", 32'(o_ReqReady), 32'd1);
    if (!o_ReqReady) return;
    i_ReqValid = 1'b1;
    i_WrEn     = wr;
    i_Funct3   = f3;
    i_Addr     = addr;
    i_DataIn   = din;
    @(posedge clk);
    model_access(wr, f3, addr, din, mdata, merr);
    #1 i_ReqValid = 1'b0;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(negedge clk);
      if (o_ReqReady) lat_ok = 0;
      if (o_RespValid != (i == int'(LAT))) lat_ok = 0;
      if (i == int'(LAT)) begin
        rdata = o_DataOut;
        rerr  = o_Err;
      end else if (o_DataOut != 32'h0) begin
        lat_ok = 0;
      end
    end
    check("resp_latency", 32'(lat_ok), 32'd1);
    @(negedge clk);
    check("after_resp", {30'h0, o_ReqReady, o_RespValid}, 32'h2);
    check("after_resp_data", o_DataOut, 32'h0);
  endtask

  // Hold reset for two edges from a negedge and check the reset output values.
  task automatic pulse_reset();
    reset      = 1'b1;
    i_ReqValid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {28'h0, o_ReqReady, o_RespValid, o_Err}, 32'h0);
    check("rst_data", o_DataOut, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
  endtask

  // Count cycles from reset release to ready; optionally present a store during the scrub.
  task automatic measure_scrub(input bit poke);
    int n = 0;
    bit resp_seen = 0;
    while (!o_ReqReady && n < 100) begin
      if (poke && n >= 5 && n < 10) begin
        i_ReqValid = 1'b1;
        i_WrEn     = 1'b1;
        i_Funct3   = 3'b010;
        i_Addr     = 12'h00C;
        i_DataIn   = 32'hFFFF_FFFF;
      end else begin
        i_ReqValid = 1'b0;
      end
      @(negedge clk);
      n++;
      if (o_RespValid) resp_seen = 1;
    end
    i_ReqValid = 1'b0;
    check("scrub_cycles", 32'(n), 32'(DEPTH));
    check("scrub_no_resp", 32'(resp_seen), 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    logic [31:0] d;
    logic [1:0] e;
    logic [31:0] md;
    logic [1:0] me;
    for (int w = 0; w < int'(DEPTH); w++) begin
      do_req(1'b0, 3'b010, 12'(w*4), 32'h0, d, e, md, me);
      check($sformatf("%s_w%0d", nm, w), d, 32'h0);
    end
  endtask

  vec_t vecs [24];

  initial begin
    logic [31:0] d;
    logic [1:0]  e;
    logic [31:0] md;
    logic [1:0]  me;
    logic        wr;
    logic [2:0]  f3;
    logic [11:0] addr;

    vecs[0]  = '{1'b1, 3'b010, 12'h010, 32'h1122_3344, 32'h0000_0000, 2'd0};
    vecs[1]  = '{1'b1, 3'b000, 12'h011, 32'hFFFF_FFAB, 32'h0000_0000, 2'd0};
    vecs[2]  = '{1'b1, 3'b001, 12'h012, 32'h1234_BEEF, 32'h0000_0000, 2'd0};
    vecs[3]  = '{1'b0, 3'b010, 12'h010, 32'h0,         32'hBEEF_AB44, 2'd0};
    vecs[4]  = '{1'b1, 3'b010, 12'h020, 32'h8000_F0FF, 32'h0000_0000, 2'd0};
    vecs[5]  = '{1'b0, 3'b000, 12'h020, 32'h0,         32'hFFFF_FFFF, 2'd0};
    vecs[6]  = '{1'b0, 3'b100, 12'h021, 32'h0,         32'h0000_00F0, 2'd0};
    vecs[7]  = '{1'b0, 3'b001, 12'h022, 32'h0,         32'hFFFF_8000, 2'd0};
    vecs[8]  = '{1'b0, 3'b101, 12'h022, 32'h0,         32'h0000_8000, 2'd0};
    vecs[9]  = '{1'b0, 3'b000, 12'h023, 32'h0,         32'hFFFF_FF80, 2'd0};
    vecs[10] = '{1'b1, 3'b010, 12'h004, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0};
    vecs[11] = '{1'b1, 3'b010, 12'h005, 32'h5555_5555, 32'h0000_0000, 2'd1};
    vecs[12] = '{1'b0, 3'b010, 12'h004, 32'h0,         32'hDEAD_BEEF, 2'd0};
    vecs[13] = '{1'b0, 3'b010, 12'h040, 32'h0,         32'h0000_0000, 2'd2};
    vecs[14] = '{1'b0, 3'b011, 12'h010, 32'h0,         32'h0000_0000, 2'd3};
    vecs[15] = '{1'b1, 3'b100, 12'h041, 32'h1,         32'h0000_0000, 2'd3};
    vecs[16] = '{1'b0, 3'b001, 12'h041, 32'h0,         32'h0000_0000, 2'd2};
    vecs[17] = '{1'b0, 3'b101, 12'h013, 32'h0,         32'h0000_0000, 2'd1};
    vecs[18] = '{1'b0, 3'b010, 12'h012, 32'h0,         32'h0000_0000, 2'd1};
    vecs[19] = '{1'b0, 3'b001, 12'h012, 32'h0,         32'hFFFF_BEEF, 2'd0};
    vecs[20] = '{1'b0, 3'b100, 12'h011, 32'h0,         32'h0000_00AB, 2'd0};
    vecs[21] = '{1'b0, 3'b010, 12'h03C, 32'h0,         32'h0000_0000, 2'd0};
    vecs[22] = '{1'b1, 3'b000, 12'h03F, 32'h0000_007F, 32'h0000_0000, 2'd0};
    vecs[23] = '{1'b0, 3'b010, 12'h03C, 32'h0,         32'h7F00_0000, 2'd0};

    reset      = 1'b1;
    i_ReqValid = 1'b0;
    i_WrEn     = 1'b0;
    i_Funct3   = 3'b000;
    i_Addr     = 12'h0;
    i_DataIn   = 32'h0;
    @(negedge clk);
    pulse_reset();
    measure_scrub(1'b0);

    for (int i = 0; i < 24; i++) begin
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].din, d, e, md, me);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (wr) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = 12'($urandom_range(0, 79));
      if ($urandom_range(0, 1) == 0) addr = addr & 12'hFFC;
      do_req(wr, f3, addr, $urandom, d, e, md, me);
      check($sformatf("rnd%0d_data", i), d, md);
      check($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
    end

    pulse_reset();
    measure_scrub(1'b1);
    check_all_zero("scrub");

    do_req(1'b1, 3'b010, 12'h004, 32'hCAFE_F00D, d, e, md, me);
    i_ReqValid = 1'b1;
    i_WrEn     = 1'b0;
    i_Funct3   = 3'b010;
    i_Addr     = 12'h004;
    @(posedge clk);
    #1 i_ReqValid = 1'b0;
    @(negedge clk);
    check("mid_wait_ready", {31'h0, o_ReqReady}, 32'h0);
    pulse_reset();
    measure_scrub(1'b0);
    check_all_zero("midrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
